// File: rtl/spi_ram_master.sv
`timescale 1ns/1ps
// SPI master for the SPI-slave + RAM subsystem: each host request becomes an address frame and a data frame.
// Define SPI_RAM_MASTER_WR_VERIFY_EN to read back every write and pulse wr_err on a mismatch.
module spi_ram_master #(
    parameter int GAP_CYCLES    = 1,
    parameter int RD_TURNAROUND = 2,
    parameter bit LSB_FIRST     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       wr_err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int CMAX_GT = (GAP_CYCLES > RD_TURNAROUND) ? GAP_CYCLES : RD_TURNAROUND;
    localparam int CMAX    = (CMAX_GT > 10) ? CMAX_GT : 10;
    localparam int CW      = $clog2(CMAX);

    localparam logic [CW-1:0] SHIFT_LAST  = CW'(9);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(7);
    localparam logic [CW-1:0] TURN_LAST   = CW'(RD_TURNAROUND - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEL,
        SHIFT,
        TURN,
        SAMPLE,
        GAP
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [1:0]    frm, nfrm;
    logic          rw_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rx, rx_n;
    logic          accept;
    logic          rd_phase;
    logic          last_frame;
    logic          rx_done;
    logic [9:0]    frame_word;
    logic [3:0]    bit_idx;
    logic          mosi_n;
    logic          ss_n_n;

    // frm[0] selects addr/data frame; frm[1] marks the write read-back pair.
    assign rd_phase   = rw_q | frm[1];
    assign frame_word = {rd_phase, frm[0], frm[0] ? (rd_phase ? 8'h00 : wdata_q) : addr_q};
`ifdef SPI_RAM_MASTER_WR_VERIFY_EN
    assign last_frame = frm[0] & rd_phase;
`else
    assign last_frame = frm[0];
`endif
    assign rx_done = (state == SAMPLE) && (cnt == SAMPLE_LAST);
    assign rx_n    = LSB_FIRST ? {MISO, rx[7:1]} : {rx[6:0], MISO};
    assign bit_idx = LSB_FIRST ? ncnt[3:0] : (4'd9 - ncnt[3:0]);

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nfrm   = frm;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    nstate = START;
                    nfrm   = 2'd0;
                    ncnt   = '0;
                end
            end
            START: nstate = SEL;
            SEL: begin
                nstate = SHIFT;
                ncnt   = '0;
            end
            SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    nstate = (frm[0] && rd_phase) ? TURN : GAP;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    nstate = SAMPLE;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    nstate = GAP;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    nstate = last_frame ? IDLE : START;
                    nfrm   = frm + 2'd1;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Pins are registered from the next state, so frm is already correct whenever SEL/SHIFT is next.
    always_comb begin
        ss_n_n = (nstate == IDLE) || (nstate == GAP);
        mosi_n = 1'b0;
        case (nstate)
            SEL:     mosi_n = rd_phase;
            SHIFT:   mosi_n = frame_word[bit_idx];
            default: mosi_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            frm       <= 2'd0;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rx        <= 8'h00;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            frm       <= nfrm;
            SS_n      <= ss_n_n;
            MOSI      <= mosi_n;
            busy      <= (nstate != IDLE);
            cmd_ready <= (nstate == IDLE);
            rd_valid  <= rx_done & ~frm[1];
            if (accept) begin
                rw_q    <= cmd_rw;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (state == SAMPLE) begin
                rx <= rx_n;
            end
            if (rx_done && !frm[1]) begin
                rd_data <= rx_n;
            end
        end
    end

`ifdef SPI_RAM_MASTER_WR_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= rx_done & frm[1] & (rx_n != wdata_q);
        end
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule
